// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the serial adder receive path.
// Holds the deserializer state encoding and the default frame width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } deser_state_t;

endpackage

// File: rtl/sa_shift_collect.sv
// Indexed capture register plus bit counter for one LSB-first frame.
// A clear in the same cycle as a shift places the incoming bit at index 0.
module sa_shift_collect
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_load,
    output logic             o_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    w_idx;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_idx         = i_clear ? '0 : r_cnt;
        w_next        = r_shift;
        w_next[w_idx] = i_bit;
    end

    assign o_last = (w_idx == CW'(WIDTH - 1));
    assign o_load = i_shift & o_last;
    assign o_data = w_next;

    // Counter returns to zero after the last bit so it never wraps past WIDTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_shift) begin
            r_shift <= w_next;
            r_cnt   <= o_last ? '0 : w_idx + CW'(1);
        end else if (i_clear) begin
            r_cnt   <= '0;
        end
    end

endmodule

// File: rtl/serial_sum_deser.sv
// Collects an LSB-first sum/cout bit stream into one parallel result (valid/ready).
// Result is valid 1 clk after the last bit; input dropped while holding sets sticky overrun.
module serial_sum_deser
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             overrun,
    output logic             frame_err
);

    deser_state_t     r_state;
    deser_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_overrun;
    logic             r_frame_err;

    logic             w_hs;
    logic             w_clear;
    logic             w_shift;
    logic             w_load;
    logic             w_last;
    logic             w_ovr_set;
    logic             w_ferr_set;
    logic [WIDTH-1:0] w_data;

    // A start is honoured anywhere except a HOLD that is not being drained.
    assign w_hs    = (r_state == HOLD) & out_ready;
    assign w_clear = start & ((r_state != HOLD) | out_ready);
    assign w_shift = bit_valid & ((r_state == SHIFT) | w_clear);

    sa_shift_collect #(
        .WIDTH (WIDTH)
    ) u_collect (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_bit   (sum_in),
        .o_data  (w_data),
        .o_load  (w_load),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ovr_set   = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_ferr_set = start;
                if (w_load) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_hs)
                    w_state_nxt = start ? SHIFT : IDLE;
                else
                    w_ovr_set = bit_valid | start;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out_sum  <= w_data;
                r_out_cout <= cout_in;
            end
            if (w_ovr_set)  r_overrun   <= 1'b1;
            if (w_ferr_set) r_frame_err <= 1'b1;
        end
    end

    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

    logic w_unused;
    assign w_unused = w_last;

endmodule

// File: tb/tb_serial_sum_deser.sv
// Bench for serial_sum_deser: directed frames plus random traffic against a queue-based model.
module tb_serial_sum_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         sum_in = 1'b0;
    logic         cout_in = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         overrun;
    logic         frame_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_sum_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    // Reference: a pending result flag, a bit queue for the open frame, sticky flags.
    bit         m_have;
    bit         m_framing;
    bit         m_ovr;
    bit         m_ferr;
    bit         m_cout;
    logic [W-1:0] m_sum;
    bit         m_q[$];

    function automatic void model_reset();
        m_have = 0; m_framing = 0; m_ovr = 0; m_ferr = 0; m_cout = 0;
        m_sum = '0;
        m_q.delete();
    endfunction

    function automatic void model_step(bit st, bit bv, bit s, bit c, bit rdy);
        bit hs;
        hs = m_have && rdy;
        if (m_have && !hs) begin
            if (bv || st) m_ovr = 1;
            return;
        end
        if (hs) m_have = 0;
        if (st) begin
            if (m_framing) m_ferr = 1;
            m_framing = 1;
            m_q.delete();
        end
        if (m_framing && bv) begin
            m_q.push_back(s);
            if (m_q.size() == W) begin
                for (int i = 0; i < W; i++) m_sum[i] = m_q[i];
                m_cout    = c;
                m_have    = 1;
                m_framing = 0;
                m_q.delete();
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_have});
        chk("out_sum",   {24'd0, out_sum},   {24'd0, m_sum});
        chk("out_cout",  {31'd0, out_cout},  {31'd0, m_cout});
        chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    endtask

    task automatic step(input bit st, input bit bv, input bit s, input bit c, input bit rdy);
        start = st; bit_valid = bv; sum_in = s; cout_in = c; out_ready = rdy;
        @(posedge clk);
        model_step(st, bv, s, c, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_frame(input logic [W-1:0] v, input bit c);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) step(0, 1, v[i], (i == W - 1) ? c : 1'b0, 0);
    endtask

    initial begin
        logic [W:0] e2e;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;

        // Bits 1,0,1,0,0,0,0,0 with cout on the last bit.
        send_frame(8'h05, 1'b1);
        chk("f1_valid", {31'd0, out_valid}, 32'd1);
        chk("f1_sum", {24'd0, out_sum}, 32'h05);
        chk("f1_cout", {31'd0, out_cout}, 32'd1);

        repeat (5) step(0, 0, 0, 0, 0);
        chk("stall_sum", {24'd0, out_sum}, 32'h05);

        repeat (3) step(0, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_sum", {24'd0, out_sum}, 32'h05);
        step(0, 0, 0, 0, 1);
        chk("hs_drop", {31'd0, out_valid}, 32'd0);

        // Restart after three bits.
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        send_frame(8'hFF, 1'b0);
        chk("ferr_flag", {31'd0, frame_err}, 32'd1);
        chk("ferr_sum", {24'd0, out_sum}, 32'hFF);
        step(0, 0, 0, 0, 1);

        // Handshake, start and bit 0 of the next frame in one cycle.
        send_frame(8'hA5, 1'b0);
        chk("b2b_a5", {24'd0, out_sum}, 32'hA5);
        step(1, 1, 1'b0, 0, 1);
        for (int i = 1; i < W; i++) begin
            logic [W-1:0] v;
            v = 8'h3C;
            step(0, 1, v[i], 0, 0);
        end
        chk("b2b_3c", {24'd0, out_sum}, 32'h3C);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a frame.
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_sum", {24'd0, out_sum}, 32'd0);
        chk("arst_ovr", {31'd0, overrun}, 32'd0);
        chk("arst_ferr", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h81, 1'b0);
        chk("post_rst", {24'd0, out_sum}, 32'h81);
        step(0, 0, 0, 0, 1);

        // Serial adder stream for 7F + 01 + 0.
        e2e = {1'b0, 8'h7F} + {1'b0, 8'h01};
        send_frame(e2e[W-1:0], e2e[W]);
        chk("e2e_sum", {24'd0, out_sum}, 32'h80);
        chk("e2e_cout", {31'd0, out_cout}, 32'd0);
        step(0, 0, 0, 0, 1);

        repeat (3000) begin
            step($urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
